nrzi_rx_unstuffer: RTL and testbench
====================================

// Module: nrzi_rx_unstuffer
// PURPOSE
//  Receive-side bit engine. It NRZI-decodes the line level on each bit strobe,
//  removes bits inserted by bit-stuffing, and flags stuff violations.
//  It detects end of packet (SE0 followed by J) and deserialises payload
//  LSB-first into WIDTH-bit words.
//  Sits between the line sampler (supplies curr_bit, se0, pulse) and the
//  packet/PID layer.
// PARAMETERS
//  WIDTH       8  bits per output word (>=2)
//  STUFF_LEN   6  consecutive decoded 1s after which a stuffed 0 follows (>=1)
//  IDLE_LEVEL  1  line level (J) assumed before first bit and restored after EOP
// PORTS
//  clk         in   1      system clock
//  nRST        in   1      asynchronous active-low reset
//  en          in   1      receive enable; 0 = synchronous clear to idle
//  pulse       in   1      bit strobe, 1 cycle per bit period; all decode work gated by it
//  curr_bit    in   1      sampled differential line level (D+ sense)
//  se0         in   1      sampled single-ended-zero, qualified by pulse
//  data_out    out  WIDTH  last completed word, bit 0 = first received bit
//  data_valid  out  1      1-cycle strobe: data_out updated this cycle
//  stuff_err   out  1      1-cycle strobe: STUFF_LEN+1 consecutive 1s seen
//  eop         out  1      1-cycle strobe: SE0 then J completed
//  busy        out  1      1 while state != IDLE
// BEHAVIOUR
//  Reset (nRST=0, async): state IDLE, prev_level=IDLE_LEVEL, ones_cnt=0, bit_idx=0,
//   shift=0, data_out=0, data_valid=0, stuff_err=0, eop=0, busy=0.
//  Outputs are registered. Strobes are high for exactly one clk, in the cycle after
//   the pulse cycle that caused them. Strobes are 0 in every other cycle.
//  pulse=0 cycles: all state held; strobes return to 0.
//  en=0 (sync, any state): IDLE, prev_level=IDLE_LEVEL, counters/shift cleared,
//   data_out held. en=0 overrides pulse.
//  Decode (pulse=1, se0=0): d = (curr_bit == prev_level); prev_level <= curr_bit.
//  Unstuff (ACTIVE):
//   - d=1, ones_cnt<STUFF_LEN: accept 1, ones_cnt+1.
//   - d=1, ones_cnt==STUFF_LEN: stuff_err, -> IDLE, partial word dropped.
//   - d=0, ones_cnt==STUFF_LEN: stuffed bit, discarded (no bit_idx advance), ones_cnt=0.
//   - d=0 otherwise: accept 0, ones_cnt=0.
//  Accepted bit: shift = {bit, shift[WIDTH-1:1]}; bit_idx+1.
//   On bit_idx==WIDTH-1: data_out <= completed word, data_valid, bit_idx=0.
//  ones_cnt width $clog2(STUFF_LEN+1); bit_idx width $clog2(WIDTH); no overflow possible.
//  FSM:
//   IDLE   -> ACTIVE on pulse & en & !se0. That first bit is decoded and unstuffed
//             normally.
//   ACTIVE -> EOP_SE0 on pulse & se0. Partial word (bit_idx!=0) is discarded silently.
//             prev_level is not updated.
//   EOP_SE0: stays while pulse & se0. On pulse & !se0: eop, prev_level<=IDLE_LEVEL,
//             -> IDLE. This J bit is not decoded.
//   IDLE with pulse & se0: ignored, stays IDLE.
//  Simultaneous: a word completing on the bit that makes ones_cnt==STUFF_LEN is emitted.
//   The following stuffed 0 is still consumed. An error on the next bit is flagged
//   after the valid.
//  Reset mid-packet: immediate return to reset values; no strobe emitted.
// TESTING
//  1 Assert nRST low mid-word, W=8 -> all outputs 0 same cycle, busy 0, no strobes.
//  2 en=1, curr_bit per pulse 0,1,0,1,0,1,0,0 (SYNC) -> data_valid once, data_out=8'h80,
//    busy=1.
//  3 Then hold curr_bit 6 pulses, toggle once, hold 2 pulses -> exactly one data_valid,
//    data_out=8'hFF, stuff_err never.
//  4 Hold curr_bit constant 7 pulses after a 0 -> stuff_err one cycle, no data_valid,
//    busy=0.
//  5 3 data bits, se0=1 for 2 pulses, then curr_bit=1/se0=0 -> eop one cycle, no
//    data_valid, busy=0, next SYNC decodes 8'h80 again.
//  6 WIDTH=16 build: 0x80 SYNC then 0x2D bytes -> one valid, data_out=16'h2D80; en=0
//    mid-word -> busy=0 next cycle, no valid; gaps of pulse=0 change nothing.

Source files
------------

// File: rtl/nrzi_rx_unstuffer.sv
`timescale 1ns/1ps
// nrzi_rx_unstuffer: receive bit engine. NRZI-decodes the sampled line level
// on each bit strobe, removes stuffed bits, flags stuff violations, detects
// end of packet (SE0 then J) and deserialises payload LSB-first into words.
//
// Ports:
//   clk        system clock
//   nRST       asynchronous active-low reset
//   en         receive enable; low = synchronous clear to idle
//   pulse      one-cycle bit strobe; all decode work is gated by it
//   curr_bit   sampled differential line level (D+ sense)
//   se0        sampled single-ended zero, qualified by pulse
//   data_out   last completed word, bit 0 = first received bit
//   data_valid one-cycle strobe: data_out updated
//   stuff_err  one-cycle strobe: STUFF_LEN+1 consecutive decoded ones
//   eop        one-cycle strobe: SE0 followed by J completed
//   busy       high while a packet is being received or terminated
module nrzi_rx_unstuffer #(
    parameter int   WIDTH      = 8,
    parameter int   STUFF_LEN  = 6,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             en,
    input  logic             pulse,
    input  logic             curr_bit,
    input  logic             se0,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             stuff_err,
    output logic             eop,
    output logic             busy
);

    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int IW = $clog2(WIDTH);

    localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);
    localparam logic [OW-1:0] ONES_ONE = OW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_EOP    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             prev_q, prev_d;
    logic [OW-1:0]    ones_q, ones_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             eop_q, eop_d;

    logic             dec_bit;
    logic             at_limit;
    logic             accept;
    logic [WIDTH-1:0] shift_in;

    // NRZI: an unchanged line level carries a 1, a transition carries a 0.
    assign dec_bit  = (curr_bit == prev_q);
    assign at_limit = (ones_q == ONES_MAX);
    assign shift_in = {dec_bit, shift_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        ones_d  = ones_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        eop_d   = 1'b0;
        accept  = 1'b0;

        if (!en) begin
            state_d = S_IDLE;
            prev_d  = IDLE_LEVEL;
            ones_d  = '0;
            idx_d   = '0;
            shift_d = '0;
        end else if (pulse) begin
            case (state_q)
                S_IDLE, S_ACTIVE: begin
                    if (se0) begin
                        // SE0 while idle is line noise; while active it
                        // starts EOP and drops any partial word.
                        if (state_q == S_ACTIVE) begin
                            state_d = S_EOP;
                            ones_d  = '0;
                            idx_d   = '0;
                            shift_d = '0;
                        end
                    end else begin
                        prev_d  = curr_bit;
                        state_d = S_ACTIVE;
                        if (dec_bit && at_limit) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                            ones_d  = '0;
                            idx_d   = '0;
                            shift_d = '0;
                        end else if (dec_bit) begin
                            ones_d = ones_q + ONES_ONE;
                            accept = 1'b1;
                        end else begin
                            // A 0 right after a full run of ones is the
                            // stuffed bit and carries no payload.
                            ones_d = '0;
                            accept = !at_limit;
                        end
                    end
                end
                S_EOP: begin
                    if (!se0) begin
                        eop_d   = 1'b1;
                        prev_d  = IDLE_LEVEL;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (accept) begin
            shift_d = shift_in;
            if (idx_q == IDX_LAST) begin
                data_d  = shift_in;
                valid_d = 1'b1;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            prev_q  <= IDLE_LEVEL;
            ones_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            ones_q  <= ones_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            eop_q   <= eop_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign stuff_err  = err_q;
    assign eop        = eop_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_nrzi_rx_unstuffer.sv
`timescale 1ns/1ps
// Bench for nrzi_rx_unstuffer: packets are built from payload bits by a
// transmit-side encoder; a monitor checks strobes against a queue.
module tb_nrzi_rx_unstuffer;

    localparam int W = 8;
    localparam int S = 6;

    logic         clk = 1'b0;
    logic         nRST = 1'b1;
    logic         en = 1'b0;
    logic         pulse = 1'b0;
    logic         curr_bit = 1'b1;
    logic         se0 = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         stuff_err;
    logic         eop;
    logic         busy;

    int total = 0;
    int bad = 0;

    typedef struct {
        int           kind;
        logic [W-1:0] word;
    } exp_t;

    typedef struct {
        bit lvl;
        bit s0;
        bit isd;
        bit b;
    } sym_t;

    exp_t         exp_q[$];
    sym_t         syms[$];
    bit           pay[$];
    logic [W-1:0] last_word = '0;

    always #5 clk = ~clk;

    nrzi_rx_unstuffer #(
        .WIDTH(W),
        .STUFF_LEN(S),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .clk(clk),
        .nRST(nRST),
        .en(en),
        .pulse(pulse),
        .curr_bit(curr_bit),
        .se0(se0),
        .data_out(data_out),
        .data_valid(data_valid),
        .stuff_err(stuff_err),
        .eop(eop),
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic pop_check(input int kind, input logic [W-1:0] val);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected strobe kind=%0d data=%0h at %0t",
                     kind, val, $time);
        end else begin
            e = exp_q.pop_front();
            check("strobe_kind", kind, e.kind);
            if (kind == 0 && e.kind == 0)
                check("data_out", val, e.word);
        end
    endtask

    // 0 = word, 1 = stuff error, 2 = eop
    always @(negedge clk) begin
        if (nRST) begin
            if (data_valid) pop_check(0, data_out);
            if (stuff_err)  pop_check(1, '0);
            if (eop)        pop_check(2, '0);
        end
    end

    task automatic add_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) pay.push_back(v[i]);
    endtask

    // mode 0: clean packet + EOP; mode 1: 0 then S+1 unstuffed ones;
    // mode 2: payload ending in a full run, stuffed 0 replaced by a 1.
    task automatic build(input int mode, input int nse0);
        bit lvl = 1'b1;
        int run = 0;
        syms.delete();
        foreach (pay[i]) begin
            if (!pay[i]) lvl = ~lvl;
            syms.push_back('{lvl, 1'b0, 1'b1, pay[i]});
            run = pay[i] ? run + 1 : 0;
            if (run == S) begin
                lvl = ~lvl;
                syms.push_back('{lvl, 1'b0, 1'b0, 1'b0});
                run = 0;
            end
        end
        if (mode == 0) begin
            repeat (nse0) syms.push_back('{lvl, 1'b1, 1'b0, 1'b0});
            syms.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
        end else if (mode == 1) begin
            lvl = ~lvl;
            syms.push_back('{lvl, 1'b0, 1'b1, 1'b0});
            repeat (S) syms.push_back('{lvl, 1'b0, 1'b1, 1'b1});
            syms.push_back('{lvl, 1'b0, 1'b0, 1'b0});
        end else begin
            void'(syms.pop_back());
            lvl = syms[syms.size()-1].lvl;
            syms.push_back('{lvl, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic expect_syms(input int k, input int fin);
        logic [W-1:0] w = '0;
        int n = 0;
        for (int i = 0; i < k; i++) begin
            if (syms[i].isd) begin
                w[n] = syms[i].b;
                n++;
                if (n == W) begin
                    exp_q.push_back('{0, w});
                    last_word = w;
                    n = 0;
                end
            end
        end
        if (fin != 0) exp_q.push_back('{fin, '0});
    endtask

    task automatic gap();
        pulse = 1'b0;
        curr_bit = 1'($urandom);
        se0 = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k);
        for (int i = 0; i < k; i++) begin
            repeat ($urandom_range(0, 2)) gap();
            pulse = 1'b1;
            curr_bit = syms[i].lvl;
            se0 = syms[i].s0;
            @(posedge clk);
            #1;
            pulse = 1'b0;
            if (i == 0) check("busy_start", busy, 1);
        end
    endtask

    task automatic clear_en();
        en = 1'b0;
        pulse = 1'($urandom);
        curr_bit = 1'($urandom);
        se0 = 1'($urandom);
        @(posedge clk);
        #1;
        en = 1'b1;
        pulse = 1'b0;
        check("busy_after_clear", busy, 0);
        check("data_held", data_out, last_word);
    endtask

    task automatic mid_reset();
        gap();
        nRST = 1'b0;
        #1;
        last_word = '0;
        check("rst_data", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_strobes", {data_valid, stuff_err, eop}, 0);
        @(posedge clk);
        #1;
        nRST = 1'b1;
    endtask

    // cut = 0 runs the whole packet; otherwise stop after cut symbols
    task automatic run_pkt(input int mode, input int nse0, input int cut,
                           input bit use_rst);
        build(mode, nse0);
        if (cut == 0) begin
            expect_syms(syms.size(), (mode == 0) ? 2 : 1);
            drive(syms.size());
            repeat (2) gap();
            check("busy_end", busy, 0);
            if (mode != 0) clear_en();
        end else begin
            expect_syms(cut, 0);
            drive(cut);
            if (use_rst) mid_reset();
            else clear_en();
        end
    endtask

    initial begin
        #2;
        nRST = 1'b0;
        #1;
        check("reset_data", data_out, 0);
        check("reset_busy", busy, 0);
        check("reset_strobes", {data_valid, stuff_err, eop}, 0);
        @(posedge clk);
        #1;
        nRST = 1'b1;
        en = 1'b1;
        repeat (2) gap();

        // SYNC then all-ones byte crossing a stuffed bit
        pay.delete(); add_byte(8'h80); add_byte(8'hFF);
        run_pkt(0, 2, 0, 1'b0);

        // SYNC, zero byte, then a stuff violation
        pay.delete(); add_byte(8'h80); add_byte(8'h00);
        run_pkt(1, 0, 0, 1'b0);

        // three bits then EOP: no word
        pay.delete(); pay.push_back(1'b0); pay.push_back(1'b1);
        pay.push_back(1'b1);
        run_pkt(0, 2, 0, 1'b0);

        pay.delete(); add_byte(8'h80);
        run_pkt(0, 1, 0, 1'b0);

        // word completes on the sixth one; stuffed 0 still consumed
        pay.delete(); add_byte(8'h80); add_byte(8'hFC); add_byte(8'h01);
        run_pkt(0, 3, 0, 1'b0);

        // word completes on the sixth one, next bit is a violation
        pay.delete(); add_byte(8'h80); add_byte(8'hFC);
        run_pkt(2, 0, 0, 1'b0);

        // mid-packet enable drop and reset
        pay.delete(); add_byte(8'h80); add_byte(8'h2D); add_byte(8'h5A);
        run_pkt(0, 2, 13, 1'b0);
        pay.delete(); add_byte(8'h80); add_byte(8'h2D); add_byte(8'h5A);
        run_pkt(0, 2, 20, 1'b1);

        for (int p = 0; p < 80; p++) begin
            int ty;
            int len;
            int nse;
            int cut;
            ty = $urandom_range(0, 9);
            len = $urandom_range(1, 40);
            nse = $urandom_range(1, 3);
            pay.delete();
            for (int i = 0; i < len; i++)
                pay.push_back(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            if (ty <= 5) begin
                run_pkt(0, nse, 0, 1'b0);
            end else if (ty <= 7) begin
                run_pkt(1, 0, 0, 1'b0);
            end else begin
                build(0, nse);
                cut = $urandom_range(1, syms.size() - 1);
                run_pkt(0, nse, cut, (ty == 9));
            end
        end

        repeat (5) gap();
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
